// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: write-arbiter state encoding and default sizing.
package fifo_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   localparam int N_REQ_DEF     = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int BURST_LEN_DEF = 4;

endpackage : fifo_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic priority picker: first set request at or after rr_ptr, wrapping around.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);

   // scan N positions starting at rr_ptr, keep the first hit
   always_comb begin
      logic found_s;
      int   j_s;
      pick    = {N{1'b0}};
      idx     = {IW{1'b0}};
      found_s = 1'b0;
      j_s     = 0;
      for (int k = 0; k < N; k++) begin
         j_s = (int'(rr_ptr) + k) % N;
         if (!found_s && req[j_s]) begin
            found_s    = 1'b1;
            pick[j_s]  = 1'b1;
            idx        = IW'(j_s);
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the FIFO write port from N_REQ requesters.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          gnt,
   input  logic                      full_flag,
   output logic                      w_en,
   output logic [DATA_W-1:0]         data_in,
   output logic                      busy,
   output logic [$clog2(N_REQ)-1:0]  owner
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(BURST_LEN) + 1;

   arb_state_e       state_q, state_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    cnt_inc_s;
   logic [N_REQ-1:0] pick_s;
   logic [IW-1:0]    pick_idx_s;
   logic [N_REQ-1:0] gnt_s;
   logic             end_s;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .pick   (pick_s),
      .idx    (pick_idx_s)
   );

   // accept strobe and write-port drive; reset suppresses any write in its cycle
   always_comb begin
      gnt_s = {N_REQ{1'b0}};
      if (state_q == ST_BURST && !rst) begin
         gnt_s[owner_q] = req[owner_q] & ~full_flag;
      end else begin
         gnt_s = {N_REQ{1'b0}};
      end
      gnt  = gnt_s;
      w_en = |gnt_s;
      if (w_en) begin
         data_in = req_data[int'(owner_q)*DATA_W +: DATA_W];
      end else begin
         data_in = {DATA_W{1'b0}};
      end
   end

   // next-state logic: arbitration in IDLE, word counting and burst termination in BURST
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      cnt_inc_s = cnt_q + CW'(1);
      end_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pick_s) begin
               state_d = ST_BURST;
               owner_d = pick_idx_s;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            // a full FIFO freezes the burst, even if the owner withdraws
            if (full_flag) begin
               end_s = 1'b0;
            end else if (!req[owner_q]) begin
               end_s = 1'b1;
            end else begin
               cnt_d = cnt_inc_s;
               end_s = (cnt_inc_s == CW'(BURST_LEN)) || req_last[owner_q];
            end
            if (end_s) begin
               state_d  = ST_IDLE;
               owner_d  = {IW{1'b0}};
               cnt_d    = {CW{1'b0}};
               rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? {IW{1'b0}} : owner_q + IW'(1);
            end else begin
               state_d = ST_BURST;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            owner_d  = {IW{1'b0}};
            cnt_d    = {CW{1'b0}};
            rr_ptr_d = {IW{1'b0}};
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= {IW{1'b0}};
         rr_ptr_q <= {IW{1'b0}};
         cnt_q    <= {CW{1'b0}};
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy  = (state_q == ST_BURST);
   assign owner = owner_q;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter at N_REQ=4, DATA_W=8, BURST_LEN=4.
module tb_fifo_wr_arbiter;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  last;
      logic        full;
      logic [3:0]  e_gnt;
      logic        e_wen;
      logic [7:0]  e_din;
      logic        e_busy;
      logic [1:0]  e_owner;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  gnt;
   logic        full_flag;
   logic        w_en;
   logic [7:0]  data_in;
   logic        busy;
   logic [1:0]  owner;

   int   n_checks;
   int   n_pass;
   int   n_vec;
   vec_t tbl[$];

   fifo_wr_arbiter #(
      .N_REQ     (4),
      .DATA_W    (8),
      .BURST_LEN (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .req_last  (req_last),
      .gnt       (gnt),
      .full_flag (full_flag),
      .w_en      (w_en),
      .data_in   (data_in),
      .busy      (busy),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                      input logic [3:0] l, input logic f, input logic [3:0] eg,
                      input logic ew, input logic [7:0] ed, input logic eb,
                      input logic [1:0] eo);
      vec_t v;
      v.rst = r; v.req = rq; v.data = d; v.last = l; v.full = f;
      v.e_gnt = eg; v.e_wen = ew; v.e_din = ed; v.e_busy = eb; v.e_owner = eo;
      tbl.push_back(v);
   endtask

   // drive at negedge, compare 1 time unit later, well before the next rising edge
   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      rst = v.rst; req = v.req; req_data = v.data; req_last = v.last; full_flag = v.full;
      #1;
      n_checks++;
      if ({gnt, w_en, data_in, busy, owner} ===
          {v.e_gnt, v.e_wen, v.e_din, v.e_busy, v.e_owner}) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got gnt=%b w_en=%b data_in=%h busy=%b owner=%0d, want gnt=%b w_en=%b data_in=%h busy=%b owner=%0d",
                  tag, gnt, w_en, data_in, busy, owner,
                  v.e_gnt, v.e_wen, v.e_din, v.e_busy, v.e_owner);
      end
   endtask

   task automatic run_table(input int lo, input int hi, input string name);
      for (int i = lo; i < hi; i++) begin
         step(tbl[i], $sformatf("%s[%0d]", name, i - lo));
      end
   endtask

   initial begin
      int   a_end;
      int   c_end;
      vec_t v;
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1; req = 4'd0; req_data = 32'd0; req_last = 4'd0; full_flag = 1'b0;
      repeat (2) @(posedge clk);

      // single requester, 6 words: 4-word burst, idle gap, then 2 words ended by req drop
      add(1'b1, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b0001, 32'h10, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b0001, 32'h10, 4'd0, 1'b0, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0);
      add(1'b0, 4'b0001, 32'h11, 4'd0, 1'b0, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);
      add(1'b0, 4'b0001, 32'h12, 4'd0, 1'b0, 4'b0001, 1'b1, 8'h12, 1'b1, 2'd0);
      add(1'b0, 4'b0001, 32'h13, 4'd0, 1'b0, 4'b0001, 1'b1, 8'h13, 1'b1, 2'd0);
      add(1'b0, 4'b0001, 32'h14, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b0001, 32'h14, 4'd0, 1'b0, 4'b0001, 1'b1, 8'h14, 1'b1, 2'd0);
      add(1'b0, 4'b0001, 32'h15, 4'd0, 1'b0, 4'b0001, 1'b1, 8'h15, 1'b1, 2'd0);
      add(1'b0, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0);
      add(1'b0, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      a_end = tbl.size();

      // owner 2 stalled by full for 3 cycles (req drops during one), non-owner reqs ignored
      add(1'b1, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b0100, 32'h00200000, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b0100, 32'h00200000, 4'd0, 1'b0, 4'b0100, 1'b1, 8'h20, 1'b1, 2'd2);
      add(1'b0, 4'b0100, 32'h00210000, 4'd0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2);
      add(1'b0, 4'b0100, 32'h00210000, 4'd0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2);
      add(1'b0, 4'b0000, 32'h00210000, 4'd0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2);
      add(1'b0, 4'b0100, 32'h00210000, 4'd0, 1'b0, 4'b0100, 1'b1, 8'h21, 1'b1, 2'd2);
      add(1'b0, 4'b1111, 32'h11221111, 4'd0, 1'b0, 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2);
      add(1'b0, 4'b0100, 32'h00230000, 4'd0, 1'b0, 4'b0100, 1'b1, 8'h23, 1'b1, 2'd2);
      add(1'b0, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      // owner 1 ends on req_last after 2 words; rr_ptr=2 makes 2 win over 1 next
      add(1'b0, 4'b0010, 32'h00003000, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b0010, 32'h00003000, 4'd0, 1'b0, 4'b0010, 1'b1, 8'h30, 1'b1, 2'd1);
      add(1'b0, 4'b0010, 32'h00003100, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h31, 1'b1, 2'd1);
      add(1'b0, 4'b0110, 32'h00403200, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b0110, 32'h00403200, 4'd0, 1'b0, 4'b0100, 1'b1, 8'h40, 1'b1, 2'd2);
      add(1'b0, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2);
      add(1'b0, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      // owner 3 aborted by reset after 2 writes; next grant restarts from index 0
      add(1'b0, 4'b1000, 32'h50000000, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b1000, 32'h50000000, 4'd0, 1'b0, 4'b1000, 1'b1, 8'h50, 1'b1, 2'd3);
      add(1'b0, 4'b1000, 32'h51000000, 4'd0, 1'b0, 4'b1000, 1'b1, 8'h51, 1'b1, 2'd3);
      add(1'b1, 4'b1001, 32'h52000060, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd3);
      add(1'b0, 4'b1001, 32'h52000060, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      add(1'b0, 4'b1001, 32'h52000060, 4'd0, 1'b0, 4'b0001, 1'b1, 8'h60, 1'b1, 2'd0);
      add(1'b0, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0);
      add(1'b0, 4'b0000, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      c_end = tbl.size();

      run_table(0, a_end, "single_req");

      // all four requesting: owners 0,1,2,3,0, 4 words each, one idle cycle between
      v.last = 4'd0; v.full = 1'b0; v.e_din = 8'h00;
      v.rst = 1'b1; v.req = 4'b0000; v.data = 32'h0;
      v.e_gnt = 4'b0000; v.e_wen = 1'b0; v.e_busy = 1'b0; v.e_owner = 2'd0;
      step(v, "rr_reset");
      v.rst = 1'b0; v.req = 4'b1111; v.data = 32'hA3A2A1A0;
      for (int b = 0; b < 5; b++) begin
         v.e_gnt = 4'b0000; v.e_wen = 1'b0; v.e_din = 8'h00; v.e_busy = 1'b0; v.e_owner = 2'd0;
         step(v, $sformatf("rr_idle%0d", b));
         for (int w = 0; w < 4; w++) begin
            v.e_gnt   = 4'b0001 << (b % 4);
            v.e_wen   = 1'b1;
            v.e_din   = 8'hA0 + 8'(b % 4);
            v.e_busy  = 1'b1;
            v.e_owner = 2'(b % 4);
            step(v, $sformatf("rr_b%0d_w%0d", b, w));
         end
      end
      v.req = 4'b0000; v.e_gnt = 4'b0000; v.e_wen = 1'b0; v.e_din = 8'h00;
      v.e_busy = 1'b0; v.e_owner = 2'd0;
      step(v, "rr_drain");

      run_table(a_end, c_end, "corner");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fifo_wr_arbiter

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter BURST_LEN, default 4, maximum words accepted per grant (1..16).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester "word valid".
REQ-007 req_data  input  N_REQ*DATA_W  packed words, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 req_last  input  N_REQ  marks requester i's current word as the last of its packet.
REQ-009 gnt  output  N_REQ  one-hot accept strobe; requester i's word is consumed in any cycle with gnt[i]=1.
REQ-010 full_flag  input  1  FIFO full, write side.
REQ-011 w_en  output  1  FIFO write enable.
REQ-012 data_in  output  DATA_W  FIFO write data.
REQ-013 busy  output  1  high while in BURST.
REQ-014 owner  output  clog2(N_REQ)  index of the current burst owner; 0 in IDLE.

Function
REQ-015 The FSM SHALL have two states, IDLE and BURST.
REQ-016 In IDLE with any req bit set, the block SHALL select the first set bit at or after rr_ptr (cyclic), load owner with it, clear the burst counter and enter BURST on the next edge; no word is accepted in IDLE.
REQ-017 In BURST, gnt[owner] SHALL equal req[owner] & ~full_flag (combinational), all other gnt bits 0.
REQ-018 w_en SHALL equal |gnt, and data_in SHALL equal req_data slice [owner] (combinational, zero latency, at most one write per cycle).
REQ-019 Each accepted word SHALL increment the burst counter (width clog2(BURST_LEN)+1, no wrap).
REQ-020 The burst SHALL end (next state IDLE) on the edge where the accepted word is the BURST_LEN-th, or carries req_last[owner]=1, or req[owner]=0 while full_flag=0.
REQ-021 At burst end, rr_ptr SHALL become (owner+1) mod N_REQ; one IDLE cycle always separates two bursts.
REQ-022 While full_flag=1 in BURST, no word is accepted; state, owner and counter SHALL hold, and req[owner]=0 SHALL NOT end the burst.
REQ-023 Changes on req of non-owners during BURST SHALL have no effect until the next IDLE arbitration.
REQ-024 With BURST_LEN=1, every accepted word SHALL end the burst.

Reset
REQ-025 On rst=1 at a rising edge: state=IDLE, rr_ptr=0, owner=0, counter=0; hence gnt=0, w_en=0, busy=0.
REQ-026 rst asserted mid-burst SHALL abort the burst with no write in that cycle (gnt forced 0 while rst=1) and no memory of the partial burst.
REQ-027 data_in SHALL be 0 whenever w_en=0.

Structure
REQ-028 State encoding (IDLE/BURST) and the default N_REQ, DATA_W and BURST_LEN constants SHALL live in the shared FIFO package, fifo_pkg.
REQ-029 Cyclic priority selection SHALL be a sub-module, rr_pick (inputs req, rr_ptr; outputs one-hot pick and index), purely combinational.
REQ-030 The block SHALL connect directly to the fifo write port (w_clk tied to clk, w_en, data_in, full_flag).

Verification
REQ-031 Reset, then req=4'b0001 held for 6 cycles with data 0x10..0x15, req_last=0: one IDLE cycle, then 4 writes 0x10..0x13, IDLE, then 0x14, 0x15 in the next burst.
REQ-032 req=4'b1111 held, all req_last=0: bursts in owner order 0,1,2,3,0, each exactly 4 writes, with 1 idle cycle between bursts.
REQ-033 Owner 2 in BURST, full_flag=1 for 3 cycles after the first write: w_en=0 for those 3 cycles, then the remaining 3 words are written and the burst ends.
REQ-034 req[1] with req_last on its 2nd word: the burst ends after 2 writes; rr_ptr=2.
REQ-035 rst pulsed after 2 writes in owner 3's burst: the next cycle has busy=0 and owner=0, and the next grant goes to the lowest set req from index 0.
